// File: rtl/fwvip_wb_monitor_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : fwvip_wb_monitor_pkg                                          |
// | Purpose : Record field offsets and width helpers for the Wishbone       |
// |           passive monitor.                                              |
// |           Record layout, MSB to LSB:                                    |
// |             adr | we | data | sel | err                                 |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
package fwvip_wb_monitor_pkg;

  // Fixed low-order fields of a monitor record.
  localparam int ERR_LSB = 0;
  localparam int SEL_LSB = 1;

  // Byte-select width derived from the data width.
  function automatic int sel_width(input int data_w);
    return data_w / 8;
  endfunction

  // Total record width: adr + data + sel + we + err.
  function automatic int mon_width(input int addr_w, input int data_w);
    return addr_w + data_w + (data_w / 8) + 2;
  endfunction

  // Least significant bit of the data field.
  function automatic int data_lsb(input int data_w);
    return (data_w / 8) + 1;
  endfunction

  // Position of the write-enable bit.
  function automatic int we_bit(input int data_w);
    return data_w + (data_w / 8) + 1;
  endfunction

  // Least significant bit of the address field.
  function automatic int adr_lsb(input int data_w);
    return data_w + (data_w / 8) + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwvip_wb_monitor_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface: fwvip_wb_monitor_if                                          |
// | Purpose  : Wishbone bus bundle observed by the monitor.                 |
// | Modports : master  - drives the request side, receives the response    |
// |            slave   - receives the request, drives the response         |
// |            monitor - observes every signal, drives nothing             |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface fwvip_wb_monitor_if
  import fwvip_wb_monitor_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = sel_width(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  ack;
  logic                  err;

  modport master (
    output adr, dat_w, cyc, stb, we, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, cyc, stb, we, sel,
    output dat_r, ack, err
  );

  modport monitor (
    input adr, dat_w, dat_r, cyc, stb, we, sel, ack, err
  );

endinterface
`default_nettype wire

// File: rtl/fwvip_wb_monitor_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fwvip_wb_monitor_fifo                                         |
// | Purpose : Synchronous record FIFO with valid/ready output and a sticky  |
// |           overflow flag for pushes that find the buffer full.           |
// | Ports   : clock      - rising-edge clock                                |
// |           reset      - asynchronous active-low reset                    |
// |           push       - write request                                    |
// |           push_data  - record to store                                  |
// |           pop_data   - head record (zero when empty)                    |
// |           pop_valid  - buffer non-empty                                 |
// |           pop_ready  - consumer accepts head this edge                  |
// |           overflow   - sticky, set when a record is dropped             |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module fwvip_wb_monitor_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  output logic      [WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  input  wire logic             pop_ready,
  output logic                  overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop_valid & pop_ready;
  // A same-edge pop frees the head slot, so a full buffer still accepts.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign pop_valid = ~empty;
  assign pop_data  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)    overflow <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define occupancy.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fwvip_wb_monitor_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fwvip_wb_monitor_core                                         |
// | Purpose : Passive Wishbone monitor. Every completed beat               |
// |           (cyc & stb & (ack | err)) becomes one record that is queued   |
// |           in a FIFO and offered on a valid/ready stream.                |
// | Ports   : clock, reset       - clock, async active-low reset            |
// |           i_adr .. i_err     - observed bus signals (inputs only)       |
// |           mon_dat/mon_valid  - record stream, head of FIFO              |
// |           mon_ready          - consumer ready                           |
// |           overflow           - sticky record-dropped flag               |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module fwvip_wb_monitor_core
  import fwvip_wb_monitor_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int SEL_WIDTH  = sel_width(DATA_WIDTH),
  parameter  int MON_WIDTH  = mon_width(ADDR_WIDTH, DATA_WIDTH),
  parameter  int FIFO_DEPTH = 4
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  input  wire logic [ADDR_WIDTH-1:0] i_adr,
  input  wire logic [DATA_WIDTH-1:0] i_dat_w,
  input  wire logic [DATA_WIDTH-1:0] i_dat_r,
  input  wire logic                  i_cyc,
  input  wire logic                  i_stb,
  input  wire logic                  i_we,
  input  wire logic [SEL_WIDTH-1:0]  i_sel,
  input  wire logic                  i_ack,
  input  wire logic                  i_err,
  output logic      [MON_WIDTH-1:0]  mon_dat,
  output logic                       mon_valid,
  input  wire logic                  mon_ready,
  output logic                       overflow
);
  localparam int ADR_LSB  = adr_lsb(DATA_WIDTH);
  localparam int WE_BIT   = we_bit(DATA_WIDTH);
  localparam int DATA_LSB = data_lsb(DATA_WIDTH);

  // Parameter sanity checks, resolved at elaboration.
  if (MON_WIDTH != mon_width(ADDR_WIDTH, DATA_WIDTH)) begin : g_bad_mon_width
    $error("MON_WIDTH must equal ADDR_WIDTH+DATA_WIDTH+SEL_WIDTH+2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic                 beat;
  logic [MON_WIDTH-1:0] record;

  // Idle bus activity (cyc or stb low) never qualifies as a beat.
  assign beat = i_cyc & i_stb & (i_ack | i_err);

  always_comb begin
    record                           = '0;
    record[ADR_LSB +: ADDR_WIDTH]    = i_adr;
    record[WE_BIT]                   = i_we;
    record[DATA_LSB +: DATA_WIDTH]   = i_we ? i_dat_w : i_dat_r;
    record[SEL_LSB +: SEL_WIDTH]     = i_sel;
    // err wins when ack and err are both asserted.
    record[ERR_LSB]                  = i_err;
  end

  fwvip_wb_monitor_fifo #(
    .WIDTH (MON_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (beat),
    .push_data (record),
    .pop_data  (mon_dat),
    .pop_valid (mon_valid),
    .pop_ready (mon_ready),
    .overflow  (overflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_fwvip_wb_monitor_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_fwvip_wb_monitor_core                                      |
// | Purpose : Directed self-checking bench for fwvip_wb_monitor_core.       |
// |           Inputs change on the falling edge; outputs are sampled on the |
// |           falling edge, half a cycle away from the capturing edge.      |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module tb_fwvip_wb_monitor_core;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MW = AW + DW + SW + 2;

  logic          clock;
  logic          reset;
  logic [MW-1:0] mon_dat;
  logic          mon_valid;
  logic          mon_ready;
  logic          overflow;

  int checks;
  int failures;

  fwvip_wb_monitor_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fwvip_wb_monitor_core #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MON_WIDTH  (MW),
    .FIFO_DEPTH (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_adr     (bus.adr),
    .i_dat_w   (bus.dat_w),
    .i_dat_r   (bus.dat_r),
    .i_cyc     (bus.cyc),
    .i_stb     (bus.stb),
    .i_we      (bus.we),
    .i_sel     (bus.sel),
    .i_ack     (bus.ack),
    .i_err     (bus.err),
    .mon_dat   (mon_dat),
    .mon_valid (mon_valid),
    .mon_ready (mon_ready),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected record, assembled independently in layout order.
  function automatic logic [MW-1:0] rec(input logic [AW-1:0] adr, input logic we,
                                        input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                                        input logic err);
    return {adr, we, dat, sel, err};
  endfunction

  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dw,
                       input logic [DW-1:0] dr, input logic [SW-1:0] sel,
                       input logic ack, input logic err);
    bus.cyc   = cyc;
    bus.stb   = stb;
    bus.we    = we;
    bus.adr   = adr;
    bus.dat_w = dw;
    bus.dat_r = dr;
    bus.sel   = sel;
    bus.ack   = ack;
    bus.err   = err;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (mon_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b want=0", mon_valid);
    end
    checks++;
    if (mon_dat !== '0) begin
      failures++; $display("FAIL reset_dat got=%h want=0", mon_dat);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL reset_overflow got=%b want=0", overflow);
    end
    reset = 1'b1;
  endtask

  task automatic test_writes();
    logic [MW-1:0] exp;
    exp = rec(32'h1000_0000, 1'b1, 32'h1234_5678, 4'hF, 1'b0);
    mon_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'hF, 1'b1, 1'b0);
      @(negedge clock);
      checks++;
      if (mon_valid !== 1'b1) begin
        failures++; $display("FAIL write%0d_valid got=%b want=1", i, mon_valid);
      end
      checks++;
      if (mon_dat !== exp) begin
        failures++; $display("FAIL write%0d_dat got=%h want=%h", i, mon_dat, exp);
      end
    end
    idle();
    @(negedge clock);
    checks++;
    if (mon_valid !== 1'b0) begin
      failures++; $display("FAIL write_drained got=%b want=0", mon_valid);
    end
  endtask

  task automatic test_read();
    logic [MW-1:0] exp;
    exp = rec(32'h0000_0020, 1'b0, 32'hDEAD_BEEF, 4'h3, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h5555_5555, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b0);
    @(negedge clock);
    idle();
    checks++;
    if (mon_valid !== 1'b1) begin
      failures++; $display("FAIL read_valid got=%b want=1", mon_valid);
    end
    checks++;
    if (mon_dat !== exp) begin
      failures++; $display("FAIL read_dat got=%h want=%h", mon_dat, exp);
    end
    @(negedge clock);
    checks++;
    if (mon_valid !== 1'b0) begin
      failures++; $display("FAIL read_drained got=%b want=0", mon_valid);
    end
  endtask

  task automatic test_err();
    logic [MW-1:0] exp;
    exp = rec(32'h30, 1'b1, 32'hCAFE_0001, 4'h1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h30, 32'hCAFE_0001, 32'h0, 4'h1, 1'b0, 1'b1);
    @(negedge clock);
    checks++;
    if (mon_dat !== exp || mon_valid !== 1'b1) begin
      failures++; $display("FAIL err_only got=%h/%b want=%h/1", mon_dat, mon_valid, exp);
    end
    // ack with strobe low must be ignored
    drive(1'b1, 1'b0, 1'b1, 32'h34, 32'h1, 32'h0, 4'hF, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (mon_valid !== 1'b0) begin
      failures++; $display("FAIL stb_low_ignored got=%b want=0", mon_valid);
    end
    // ack with cycle low must be ignored
    drive(1'b0, 1'b1, 1'b1, 32'h38, 32'h2, 32'h0, 4'hF, 1'b1, 1'b1);
    @(negedge clock);
    checks++;
    if (mon_valid !== 1'b0) begin
      failures++; $display("FAIL cyc_low_ignored got=%b want=0", mon_valid);
    end
    // ack and err together record err=1
    exp = rec(32'h40, 1'b0, 32'h0BAD_F00D, 4'hC, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0BAD_F00D, 4'hC, 1'b1, 1'b1);
    @(negedge clock);
    idle();
    checks++;
    if (mon_dat !== exp) begin
      failures++; $display("FAIL ack_and_err got=%h want=%h", mon_dat, exp);
    end
    @(negedge clock);
  endtask

  task automatic test_overflow();
    logic [MW-1:0] exp [7];
    for (int i = 0; i < 7; i++)
      exp[i] = rec(32'h100 + 32'(i * 4), 1'b1, 32'hA000_0000 + 32'(i), 4'hF, 1'b0);
    mon_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 32'h0,
            4'hF, 1'b1, 1'b0);
      @(negedge clock);
      checks++;
      if (mon_dat !== exp[0] || mon_valid !== 1'b1) begin
        failures++; $display("FAIL hold%0d got=%h/%b want=%h/1", i, mon_dat, mon_valid, exp[0]);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL overflow_set got=%b want=1", overflow);
    end
    // Full FIFO with push and pop on the same edge: no drop, record 6 enters.
    mon_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h118, 32'hA000_0006, 32'h0, 4'hF, 1'b1, 1'b0);
    @(negedge clock);
    idle();
    checks++;
    if (mon_dat !== exp[1]) begin
      failures++; $display("FAIL drain1 got=%h want=%h", mon_dat, exp[1]);
    end
    @(negedge clock);
    checks++;
    if (mon_dat !== exp[2]) begin
      failures++; $display("FAIL drain2 got=%h want=%h", mon_dat, exp[2]);
    end
    @(negedge clock);
    checks++;
    if (mon_dat !== exp[3]) begin
      failures++; $display("FAIL drain3 got=%h want=%h", mon_dat, exp[3]);
    end
    @(negedge clock);
    checks++;
    if (mon_dat !== exp[6] || mon_valid !== 1'b1) begin
      failures++; $display("FAIL drain_full_push got=%h/%b want=%h/1", mon_dat, mon_valid, exp[6]);
    end
    @(negedge clock);
    checks++;
    if (mon_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++; $display("FAIL drained_sticky got=%b/%b want=0/1", mon_valid, overflow);
    end
  endtask

  task automatic test_reset_mid();
    mon_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h200 + 32'(i), 32'h7700 + 32'(i), 32'h0, 4'hF, 1'b1, 1'b0);
      @(negedge clock);
    end
    idle();
    checks++;
    if (mon_valid !== 1'b1) begin
      failures++; $display("FAIL pre_reset_valid got=%b want=1", mon_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mon_valid !== 1'b0 || mon_dat !== '0 || overflow !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%b/%h/%b want=0/0/0", mon_valid, mon_dat, overflow);
    end
    // A beat completing under reset must not be recorded.
    drive(1'b1, 1'b1, 1'b1, 32'h300, 32'h9999, 32'h0, 4'hF, 1'b1, 1'b0);
    @(negedge clock);
    @(negedge clock);
    idle();
    reset = 1'b1;
    mon_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (mon_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_stale1 got=%b want=0", mon_valid);
    end
    @(negedge clock);
    checks++;
    if (mon_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL post_reset_stale2 got=%b/%b want=0/0", mon_valid, overflow);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    mon_ready = 1'b0;
    idle();
    test_reset();
    test_writes();
    test_read();
    test_err();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
